// File: rtl/apb_demux_reg_pkg.sv
// Shared types and constants for the registered APB demultiplexer.
// The TOUT state exists only when APB_DEMUX_TIMEOUT_EN is defined.
// The struct typedefs use the default 32-bit address/data, 4-port geometry.
// Instantiations with other widths flatten their ports to the same field order.
package apb_demux_reg_pkg;

  localparam int DefaultTimeout   = 256;
  localparam int DefaultAddrWidth = 32;
  localparam int DefaultDataWidth = 32;
  localparam int DefaultIdxWidth  = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    ERR    = 3'd3
`ifdef APB_DEMUX_TIMEOUT_EN
    ,
    TOUT   = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [DefaultAddrWidth-1:0]   paddr;
    logic [2:0]                    pprot;
    logic                          psel;
    logic                          penable;
    logic                          pwrite;
    logic [DefaultDataWidth-1:0]   pwdata;
    logic [DefaultDataWidth/8-1:0] pstrb;
  } req_t;

  typedef struct packed {
    logic                        pready;
    logic [DefaultDataWidth-1:0] prdata;
    logic                        pslverr;
  } resp_t;

  // The end address is exclusive.
  typedef struct packed {
    logic [DefaultIdxWidth-1:0]  idx;
    logic [DefaultAddrWidth-1:0] start_addr;
    logic [DefaultAddrWidth-1:0] end_addr;
  } rule_t;

  function automatic rule_t make_rule(input logic [DefaultIdxWidth-1:0]  idx,
                                      input logic [DefaultAddrWidth-1:0] start_addr,
                                      input logic [DefaultAddrWidth-1:0] end_addr);
    rule_t r;
    r.idx        = idx;
    r.start_addr = start_addr;
    r.end_addr   = end_addr;
    return r;
  endfunction

endpackage

// File: rtl/apb_demux_reg_decode.sv
// Combinational address-map lookup.
// The lowest-numbered matching rule wins.
// The rule ranges are [start_addr, end_addr).
// Rule idx values are assumed to name an existing port.
module apb_demux_reg_decode
  import apb_demux_reg_pkg::*;
#(
  parameter int NoRules   = 4,
  parameter int AddrWidth = 32,
  parameter int IdxWidth  = 2,
  localparam int RuleWidth = IdxWidth + 2 * AddrWidth
) (
  input  logic [AddrWidth-1:0]               addr_i,
  input  logic [NoRules-1:0][RuleWidth-1:0]  addr_map_i,
  output logic [IdxWidth-1:0]                idx_o,
  output logic                               valid_o,
  output logic                               error_o
);

  typedef struct packed {
    logic [IdxWidth-1:0]  idx;
    logic [AddrWidth-1:0] start_addr;
    logic [AddrWidth-1:0] end_addr;
  } rule_p_t;

  rule_p_t [NoRules-1:0] rules;
  assign rules = addr_map_i;

  // Scan from the highest rule down so that the lowest matching rule is the last one written.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = NoRules - 1; i >= 0; i--) begin
      if ((addr_i >= rules[i].start_addr) && (addr_i < rules[i].end_addr)) begin
        idx_o   = rules[i].idx;
        valid_o = 1'b1;
      end
    end
  end

  assign error_o = ~valid_o;

endmodule

// File: rtl/apb_demux_reg.sv
// Registered, address-decoding APB demultiplexer. It has one completer port and NoMstPorts requester ports.
// Optional feature macro: APB_DEMUX_TIMEOUT_EN adds an access-phase watchdog and the TOUT state.
// Port vectors are flat packed copies of the package structs. Field order:
//   req  = {paddr, pprot, psel, penable, pwrite, pwdata, pstrb}
//   resp = {pready, prdata, pslverr}
//   rule = {idx, start_addr, end_addr}
// Handshake: a transfer is accepted in IDLE on psel & ~penable.
// The upstream side must hold psel until it sees pready=1.
// Dropping psel early abandons the transfer without any response.
module apb_demux_reg
  import apb_demux_reg_pkg::*;
#(
  parameter int NoMstPorts    = 4,
  parameter int NoRules       = 4,
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = DefaultTimeout,
  localparam int IdxWidth   = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1,
  localparam int ReqWidth   = AddrWidth + DataWidth + DataWidth / 8 + 6,
  localparam int RespWidth  = DataWidth + 2,
  localparam int RuleWidth  = IdxWidth + 2 * AddrWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NoRules-1:0][RuleWidth-1:0]   addr_map_i,
  input  logic [ReqWidth-1:0]                 slv_req_i,
  output logic [RespWidth-1:0]                slv_resp_o,
  output logic [NoMstPorts-1:0][ReqWidth-1:0] mst_req_o,
  input  logic [NoMstPorts-1:0][RespWidth-1:0] mst_resp_i,
  output logic [2:0]                          dbg_state_o
);

  typedef struct packed {
    logic [AddrWidth-1:0]   paddr;
    logic [2:0]             pprot;
    logic                   psel;
    logic                   penable;
    logic                   pwrite;
    logic [DataWidth-1:0]   pwdata;
    logic [DataWidth/8-1:0] pstrb;
  } req_p_t;

  typedef struct packed {
    logic                 pready;
    logic [DataWidth-1:0] prdata;
    logic                 pslverr;
  } resp_p_t;

  req_p_t                    slv_req;
  resp_p_t                   slv_resp;
  req_p_t  [NoMstPorts-1:0]  mst_req;
  resp_p_t [NoMstPorts-1:0]  mst_resp;

  assign slv_req    = slv_req_i;
  assign mst_resp   = mst_resp_i;
  assign slv_resp_o = slv_resp;
  assign mst_req_o  = mst_req;

  state_e               state_q, state_d;
  req_p_t               req_q, req_d;
  logic [IdxWidth-1:0]  idx_q, idx_d;

  logic [IdxWidth-1:0]  dec_idx;
  logic                 dec_valid;
  logic                 dec_error;

  apb_demux_reg_decode #(
    .NoRules   (NoRules),
    .AddrWidth (AddrWidth),
    .IdxWidth  (IdxWidth)
  ) u_decode (
    .addr_i     (slv_req.paddr),
    .addr_map_i (addr_map_i),
    .idx_o      (dec_idx),
    .valid_o    (dec_valid),
    .error_o    (dec_error)
  );

`ifdef APB_DEMUX_TIMEOUT_EN
  localparam int CntWidth = $clog2(TimeoutCycles + 1);
  logic [CntWidth-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TimeoutCycles > 0);
`endif

  assign dbg_state_o = state_q;

  // Next-state, latch update and output drive for the transfer FSM.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    idx_d    = idx_q;
    slv_resp = '0;
    mst_req  = '0;
`ifdef APB_DEMUX_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (slv_req.psel && !slv_req.penable) begin
          if (dec_error) begin
            state_d = ERR;
          end else begin
            req_d   = slv_req;
            idx_d   = dec_idx;
            state_d = SETUP;
          end
        end
      end

      SETUP: begin
        mst_req[idx_q]         = req_q;
        mst_req[idx_q].psel    = 1'b1;
        mst_req[idx_q].penable = 1'b0;
        state_d                = ACCESS;
`ifdef APB_DEMUX_TIMEOUT_EN
        cnt_d                  = '0;
`endif
      end

      ACCESS: begin
        mst_req[idx_q]         = req_q;
        mst_req[idx_q].psel    = 1'b1;
        mst_req[idx_q].penable = 1'b1;
        slv_resp               = mst_resp[idx_q];
        if (mst_resp[idx_q].pready) begin
          state_d = IDLE;
        end else begin
`ifdef APB_DEMUX_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntWidth'(TimeoutCycles - 1)) begin
            state_d = TOUT;
          end
`endif
        end
      end

      ERR: begin
        slv_resp.pready  = 1'b1;
        slv_resp.pslverr = 1'b1;
        state_d          = IDLE;
      end

`ifdef APB_DEMUX_TIMEOUT_EN
      TOUT: begin
        slv_resp.pready  = 1'b1;
        slv_resp.pslverr = 1'b1;
        state_d          = IDLE;
      end
`endif

      default: begin
        state_d = IDLE;
      end
    endcase

    // An upstream that lets go of psel mid-transfer gets no response.
    // The downstream request is released when the FSM reaches IDLE on the next cycle.
    if ((state_q != IDLE) && !slv_req.psel) begin
      state_d  = IDLE;
      slv_resp = '0;
    end
  end

  // State, latched request and port index registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      idx_q   <= idx_d;
    end
  end

`ifdef APB_DEMUX_TIMEOUT_EN
  // Access-phase watchdog counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb_demux_reg.sv
// Directed bench for apb_demux_reg.
// Inputs change 1 time unit after the rising edge. Outputs are checked on the falling edge.
module tb_apb_demux_reg;
  import apb_demux_reg_pkg::*;

  logic            clk = 1'b0;
  logic            rst_i;
  rule_t [3:0]     addr_map;
  req_t            slv_req;
  resp_t           slv_resp;
  req_t  [3:0]     mst_req;
  resp_t [3:0]     mst_resp;
  logic  [2:0]     dbg_state;

  int checks = 0;
  int errors = 0;

  req_t  [3:0] exp_mst;
  req_t        exp_req;
  resp_t       exp_resp;
  resp_t       err_resp;
  req_t        wr;
  req_t        rd;

  apb_demux_reg #(
    .NoMstPorts    (4),
    .NoRules       (4),
    .AddrWidth     (32),
    .DataWidth     (32),
    .TimeoutCycles (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .addr_map_i  (addr_map),
    .slv_req_i   (slv_req),
    .slv_resp_o  (slv_resp),
    .mst_req_o   (mst_req),
    .mst_resp_i  (mst_resp),
    .dbg_state_o (dbg_state)
  );

  // Clock generation
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=simulation still running expected=finished");
    $fatal(1, "bench time limit");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  function automatic req_t phase(input req_t r, input logic en);
    req_t o;
    o         = r;
    o.psel    = 1'b1;
    o.penable = en;
    return o;
  endfunction

  initial begin
    err_resp         = '0;
    err_resp.pready  = 1'b1;
    err_resp.pslverr = 1'b1;
    for (int p = 0; p < 4; p++) begin
      addr_map[p] = make_rule(2'(p), 32'(p * 32'h1000), 32'((p + 1) * 32'h1000));
    end
    slv_req  = '0;
    mst_resp = '0;
    rst_i    = 1'b1;

    // Reset state
    cyc(); cyc();
    smp();
    chk("reset slv_resp", slv_resp, '0);
    chk("reset mst_req", mst_req, '0);
    chk("reset state", dbg_state, IDLE);
    cyc();
    rst_i = 1'b0;

    // Write 0x2004 to port 2, which is ready immediately. Upstream fields are scrambled after acceptance.
    wr = '0; wr.paddr = 32'h2004; wr.pprot = 3'b010; wr.pwrite = 1'b1;
    wr.pwdata = 32'hDEADBEEF; wr.pstrb = 4'hF;
    cyc();
    slv_req = phase(wr, 1'b0);
    smp();
    chk("wr T slv_resp", slv_resp, '0);
    chk("wr T mst_req", mst_req, '0);
    cyc();
    slv_req = phase(wr, 1'b1);
    slv_req.pwdata = 32'h0BADF00D;
    slv_req.paddr  = 32'h0000_0008;
    smp();
    exp_mst = '0; exp_mst[2] = phase(wr, 1'b0);
    chk("wr T+1 setup", mst_req, exp_mst);
    chk("wr T+1 state", dbg_state, SETUP);
    chk("wr T+1 pready", slv_resp.pready, 1'b0);
    cyc();
    mst_resp[2] = '0; mst_resp[2].pready = 1'b1;
    smp();
    exp_mst = '0; exp_mst[2] = phase(wr, 1'b1);
    chk("wr T+2 access", mst_req, exp_mst);
    exp_resp = '0; exp_resp.pready = 1'b1;
    chk("wr T+2 slv_resp", slv_resp, exp_resp);
    cyc();
    slv_req = '0; mst_resp = '0;
    smp();
    chk("wr T+3 idle", dbg_state, IDLE);
    chk("wr T+3 mst_req", mst_req, '0);

    // Read 0x0010 from port 0, which has 5 wait cycles and then returns 0x1234
    rd = '0; rd.paddr = 32'h0010; rd.pprot = 3'b001;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
    smp();
    exp_mst = '0; exp_mst[0] = phase(rd, 1'b0);
    chk("rd T+1 setup", mst_req, exp_mst);
    for (int w = 0; w < 5; w++) begin
      cyc();
      smp();
      exp_mst = '0; exp_mst[0] = phase(rd, 1'b1);
      chk("rd wait access", mst_req, exp_mst);
      chk("rd wait pready", slv_resp.pready, 1'b0);
    end
    cyc();
    mst_resp[0].pready = 1'b1; mst_resp[0].prdata = 32'h1234; mst_resp[0].pslverr = 1'b0;
    smp();
    exp_resp = '0; exp_resp.pready = 1'b1; exp_resp.prdata = 32'h1234;
    chk("rd T+7 slv_resp", slv_resp, exp_resp);
    cyc();
    slv_req = '0; mst_resp = '0;
    smp();
    chk("rd T+8 idle", dbg_state, IDLE);

    // Read 0x9000 is unmapped, so the decode error completes at T+1
    rd = '0; rd.paddr = 32'h9000;
    cyc();
    slv_req = phase(rd, 1'b0);
    smp();
    chk("unmapped T resp", slv_resp, '0);
    cyc();
    slv_req = phase(rd, 1'b1);
    smp();
    chk("unmapped T+1 resp", slv_resp, err_resp);
    chk("unmapped T+1 mst_req", mst_req, '0);
    chk("unmapped T+1 state", dbg_state, ERR);
    cyc();
    slv_req = '0;
    smp();
    chk("unmapped T+2 resp", slv_resp, '0);

    // 0x4000 is just past the last rule's exclusive end
    rd = '0; rd.paddr = 32'h4000;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
    smp();
    chk("edge 0x4000 resp", slv_resp, err_resp);
    chk("edge 0x4000 mst_req", mst_req, '0);
    cyc();
    slv_req = '0;

    // 0x3FFC is the last word of port 3
    rd = '0; rd.paddr = 32'h3FFC;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
    smp();
    exp_mst = '0; exp_mst[3] = phase(rd, 1'b0);
    chk("edge 0x3FFC setup", mst_req, exp_mst);
    cyc();
    mst_resp[3].pready = 1'b1; mst_resp[3].prdata = 32'hA5A5_0003;
    smp();
    exp_resp = '0; exp_resp.pready = 1'b1; exp_resp.prdata = 32'hA5A5_0003;
    chk("edge 0x3FFC resp", slv_resp, exp_resp);
    cyc();
    slv_req = '0; mst_resp = '0;

    // Port 1 never becomes ready
    rd = '0; rd.paddr = 32'h1008;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
`ifdef APB_DEMUX_TIMEOUT_EN
    for (int w = 2; w <= 9; w++) begin
      cyc();
      smp();
      chk("tout wait pready", slv_resp.pready, 1'b0);
      chk("tout wait psel1", mst_req[1].psel, 1'b1);
    end
    cyc();
    smp();
    chk("tout T+10 resp", slv_resp, err_resp);
    chk("tout T+10 mst_req", mst_req, '0);
    chk("tout T+10 state", dbg_state, TOUT);
    cyc();
    slv_req = '0;
    smp();
    chk("tout T+11 idle", dbg_state, IDLE);
`else
    for (int w = 2; w <= 14; w++) begin
      cyc();
      smp();
      chk("hang wait pready", slv_resp.pready, 1'b0);
    end
    exp_mst = '0; exp_mst[1] = phase(rd, 1'b1);
    chk("hang still access", mst_req, exp_mst);
    cyc();
    slv_req = '0;
    smp();
    chk("hang abort resp", slv_resp, '0);
    cyc();
    smp();
    chk("hang abort idle", dbg_state, IDLE);
    chk("hang abort mst_req", mst_req, '0);
`endif

    // Upstream drops psel in ACCESS. No response is given, even with a downstream pready.
    rd = '0; rd.paddr = 32'h0040;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
    cyc();
    smp();
    chk("abort access state", dbg_state, ACCESS);
    cyc();
    slv_req = '0;
    mst_resp[0].pready = 1'b1; mst_resp[0].prdata = 32'h7777;
    smp();
    chk("abort resp silent", slv_resp, '0);
    cyc();
    mst_resp = '0;
    smp();
    chk("abort idle", dbg_state, IDLE);
    chk("abort mst_req", mst_req, '0);

    // Reset asserted in the first ACCESS cycle
    wr = '0; wr.paddr = 32'h1100; wr.pwrite = 1'b1; wr.pwdata = 32'h1111_2222; wr.pstrb = 4'h3;
    cyc();
    slv_req = phase(wr, 1'b0);
    cyc();
    slv_req = phase(wr, 1'b1);
    cyc();
    rst_i = 1'b1;
    smp();
    chk("rst pre access", dbg_state, ACCESS);
    cyc();
    rst_i = 1'b0; slv_req = '0;
    smp();
    chk("rst post state", dbg_state, IDLE);
    chk("rst post mst_req", mst_req, '0);
    chk("rst post resp", slv_resp, '0);
    wr = '0; wr.paddr = 32'h3000; wr.pwrite = 1'b1; wr.pwdata = 32'hCAFE_0300; wr.pstrb = 4'hC;
    cyc();
    slv_req = phase(wr, 1'b0);
    cyc();
    slv_req = phase(wr, 1'b1);
    smp();
    exp_mst = '0; exp_mst[3] = phase(wr, 1'b0);
    chk("post-rst setup p3", mst_req, exp_mst);
    cyc();
    mst_resp[3].pready = 1'b1;
    smp();
    exp_mst = '0; exp_mst[3] = phase(wr, 1'b1);
    chk("post-rst access p3", mst_req, exp_mst);
    exp_resp = '0; exp_resp.pready = 1'b1;
    chk("post-rst resp", slv_resp, exp_resp);
    cyc();
    slv_req = '0; mst_resp = '0;

    // Overlapping rules 0 and 1 both cover 0x1000. Rule 0 points at port 2.
    addr_map[0] = make_rule(2'd2, 32'h0000, 32'h2000);
    addr_map[1] = make_rule(2'd1, 32'h1000, 32'h2000);
    rd = '0; rd.paddr = 32'h1000;
    cyc();
    slv_req = phase(rd, 1'b0);
    cyc();
    slv_req = phase(rd, 1'b1);
    smp();
    exp_mst = '0; exp_mst[2] = phase(rd, 1'b0);
    chk("overlap setup p2", mst_req, exp_mst);
    cyc();
    mst_resp[2].pready = 1'b1; mst_resp[2].prdata = 32'h0000_0B0B; mst_resp[2].pslverr = 1'b1;
    smp();
    exp_resp = '0; exp_resp.pready = 1'b1; exp_resp.prdata = 32'h0000_0B0B; exp_resp.pslverr = 1'b1;
    chk("overlap resp mirror", slv_resp, exp_resp);
    cyc();
    slv_req = '0; mst_resp = '0;
    smp();
    chk("overlap idle", dbg_state, IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
